// File: rtl/decode_stage_if.sv
// decode_stage_if: the signal bundle between the decode stage and its neighbours.
//
// The bundle covers these groups:
//   - Fetch and hazard side: en_d, instr_f, pc4_f.
//   - Write-back side: wb_we, wb_addr, wb_data.
//   - Forwarding unit: fwd_rs_sel, fwd_rt_sel, fwd_e_data, fwd_m_data.
//   - Decode results: instr_d, pc4_d, rs_data_d, rt_data_d, gpr_rs,
//     ext_imm, ext_index, pc_src.
//
// The pipeline fabric drives its side through the master modport.
// The decode stage uses the slave modport.
interface decode_stage_if;
  logic        en_d;
  logic [31:0] instr_f;
  logic [31:0] pc4_f;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [31:0] fwd_e_data;
  logic [31:0] fwd_m_data;
  logic [31:0] instr_d;
  logic [31:0] pc4_d;
  logic [31:0] rs_data_d;
  logic [31:0] rt_data_d;
  logic [31:0] gpr_rs;
  logic [31:0] ext_imm;
  logic [31:0] ext_index;
  logic [1:0]  pc_src;

  modport master (
    output en_d, instr_f, pc4_f, wb_we, wb_addr, wb_data,
           fwd_rs_sel, fwd_rt_sel, fwd_e_data, fwd_m_data,
    input  instr_d, pc4_d, rs_data_d, rt_data_d, gpr_rs,
           ext_imm, ext_index, pc_src
  );

  modport slave (
    input  en_d, instr_f, pc4_f, wb_we, wb_addr, wb_data,
           fwd_rs_sel, fwd_rt_sel, fwd_e_data, fwd_m_data,
    output instr_d, pc4_d, rs_data_d, rt_data_d, gpr_rs,
           ext_imm, ext_index, pc_src
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: the D stage of the five-stage MIPS pipeline.
//
// The stage contains:
//   - The IF/ID register.
//   - The 32x32 register file, with a write-to-read bypass.
//   - D-stage operand forwarding.
//   - Early branch and jump resolution.
//
// Branches and jumps have one delay slot, so nothing is flushed here.
//
// Ports:
//   clk   - rising-edge clock.
//   reset - synchronous, active-high reset.
//   dif   - decode_stage_if slave modport (all data and control signals).
module decode_stage #(
  parameter logic [31:0] RESET_PC4 = 32'h0000_3004
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave dif
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  localparam logic [1:0] PCS_SEQ    = 2'd0;
  localparam logic [1:0] PCS_BRANCH = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_JR     = 2'd3;

  // Sign-extends a 16-bit immediate. The fetch stage applies the <<2.
  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Selects one operand source. Encoding 3 is reserved and falls back to the register file.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf_val,
                                          input logic [31:0] e_val,
                                          input logic [31:0] m_val);
    case (sel)
      2'd1:    return e_val;
      2'd2:    return m_val;
      default: return rf_val;
    endcase
  endfunction

  logic [31:0] instr_r;
  logic [31:0] pc4_r;
  logic [31:0] gpr_r [32];

  logic [4:0]  rs_addr_s;
  logic [4:0]  rt_addr_s;
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [31:0] rf_rs_s;
  logic [31:0] rf_rt_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic [1:0]  pc_src_s;
  logic        wb_hit_s;

  assign rs_addr_s = instr_r[25:21];
  assign rt_addr_s = instr_r[20:16];
  assign opcode_s  = instr_r[31:26];
  assign funct_s   = instr_r[5:0];

  // An active write to a non-zero register. Both the write port and the bypass use it.
  assign wb_hit_s  = dif.wb_we && (dif.wb_addr != 5'd0);

  // IF/ID pipeline register. It holds while en_d is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r <= 32'h0000_0000;
      pc4_r   <= RESET_PC4;
    end else if (dif.en_d) begin
      instr_r <= dif.instr_f;
      pc4_r   <= dif.pc4_f;
    end else begin
      instr_r <= instr_r;
      pc4_r   <= pc4_r;
    end
  end

  // Register file write port. Reset wins over a pending write. $0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= 32'h0000_0000;
      end
    end else if (wb_hit_s) begin
      gpr_r[dif.wb_addr] <= dif.wb_data;
    end else begin
      gpr_r <= gpr_r;
    end
  end

  // Register file read ports with the write-to-read bypass. $0 always reads zero.
  always_comb begin
    rf_rs_s = 32'h0000_0000;
    rf_rt_s = 32'h0000_0000;
    if (rs_addr_s == 5'd0) begin
      rf_rs_s = 32'h0000_0000;
    end else if (wb_hit_s && (dif.wb_addr == rs_addr_s)) begin
      rf_rs_s = dif.wb_data;
    end else begin
      rf_rs_s = gpr_r[rs_addr_s];
    end
    if (rt_addr_s == 5'd0) begin
      rf_rt_s = 32'h0000_0000;
    end else if (wb_hit_s && (dif.wb_addr == rt_addr_s)) begin
      rf_rt_s = dif.wb_data;
    end else begin
      rf_rt_s = gpr_r[rt_addr_s];
    end
  end

  assign rs_val_s = fwd_mux(dif.fwd_rs_sel, rf_rs_s, dif.fwd_e_data, dif.fwd_m_data);
  assign rt_val_s = fwd_mux(dif.fwd_rt_sel, rf_rt_s, dif.fwd_e_data, dif.fwd_m_data);

  // Early next-PC resolution. This is re-evaluated every cycle, including during a stall.
  always_comb begin
    pc_src_s = PCS_SEQ;
    case (opcode_s)
      OP_BEQ:     pc_src_s = (rs_val_s == rt_val_s) ? PCS_BRANCH : PCS_SEQ;
      OP_BNE:     pc_src_s = (rs_val_s != rt_val_s) ? PCS_BRANCH : PCS_SEQ;
      OP_J,
      OP_JAL:     pc_src_s = PCS_JUMP;
      OP_SPECIAL: begin
        if (funct_s == FN_JR) begin
          pc_src_s = PCS_JR;
        end else begin
          pc_src_s = PCS_SEQ;
        end
      end
      default:    pc_src_s = PCS_SEQ;
    endcase
  end

  assign dif.instr_d   = instr_r;
  assign dif.pc4_d     = pc4_r;
  assign dif.rs_data_d = rs_val_s;
  assign dif.rt_data_d = rt_val_s;
  assign dif.gpr_rs    = rs_val_s;
  assign dif.ext_imm   = sign_ext16(instr_r[15:0]);
  assign dif.ext_index = {pc4_r[31:28], instr_r[25:0], 2'b00};
  assign dif.pc_src    = pc_src_s;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
//
// Inputs are driven 1 time unit after a rising edge.
// Outputs are sampled before the next rising edge.
module tb_decode_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  decode_stage_if dif ();

  decode_stage #(.RESET_PC4(32'h0000_3004)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs from the expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advances one clock edge and settles just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads one instruction and PC+4 into IF/ID, then stalls so that they stay in D.
  task automatic load_instr(input logic [31:0] instr, input logic [31:0] pc4);
    dif.en_d    = 1'b1;
    dif.instr_f = instr;
    dif.pc4_f   = pc4;
    tick();
    dif.en_d    = 1'b0;
    #1;
  endtask

  // Performs one register-file write.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    dif.wb_we   = 1'b1;
    dif.wb_addr = a;
    dif.wb_data = d;
    tick();
    dif.wb_we   = 1'b0;
  endtask

  // Builds an R-type instruction that only names rs, for register-file read probes.
  function automatic logic [31:0] rs_probe(input logic [4:0] r);
    return {6'd0, r, 5'd0, 5'd1, 5'd0, 6'b100001};
  endfunction

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    dif.en_d       = 1'b1;
    dif.instr_f    = 32'hFFFF_FFFF;
    dif.pc4_f      = 32'h1234_5678;
    dif.wb_we      = 1'b1;
    dif.wb_addr    = 5'd7;
    dif.wb_data    = 32'h0000_1234;
    dif.fwd_rs_sel = 2'd0;
    dif.fwd_rt_sel = 2'd0;
    dif.fwd_e_data = 32'h0000_0055;
    dif.fwd_m_data = 32'h0000_0001;
    tick();
    tick();
    reset     = 1'b0;
    dif.wb_we = 1'b0;
    dif.en_d  = 1'b0;
    #1;

    // Reset state.
    check("rst_instr", dif.instr_d, 32'h0000_0000);
    check("rst_pc4", dif.pc4_d, 32'h0000_3004);
    check("rst_pcsrc", {30'd0, dif.pc_src}, 32'd0);
    check("rst_imm", dif.ext_imm, 32'h0000_0000);
    check("rst_index", dif.ext_index, 32'h0000_0000);
    check("rst_rs", dif.rs_data_d, 32'h0000_0000);
    check("rst_gpr_rs", dif.gpr_rs, 32'h0000_0000);
    for (int r = 0; r < 32; r++) begin
      load_instr(rs_probe(5'(r)), 32'h0000_3008);
      check($sformatf("rst_reg%0d", r), dif.rs_data_d, 32'h0000_0000);
    end

    // Bypass: the written value is visible both before and after the edge.
    load_instr(rs_probe(5'd5), 32'h0000_3010);
    dif.wb_we   = 1'b1;
    dif.wb_addr = 5'd5;
    dif.wb_data = 32'hDEAD_BEEF;
    #1;
    check("byp_before", dif.rs_data_d, 32'hDEAD_BEEF);
    tick();
    dif.wb_we = 1'b0;
    #1;
    check("byp_after", dif.rs_data_d, 32'hDEAD_BEEF);

    // Writes to $0 are ignored.
    load_instr(rs_probe(5'd0), 32'h0000_3014);
    dif.wb_we   = 1'b1;
    dif.wb_addr = 5'd0;
    dif.wb_data = 32'hFFFF_FFFF;
    #1;
    check("r0_byp", dif.rs_data_d, 32'h0000_0000);
    tick();
    dif.wb_we = 1'b0;
    #1;
    check("r0_after", dif.rs_data_d, 32'h0000_0000);

    // beq $1,$2,-3.
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd7);
    load_instr({6'b000100, 5'd1, 5'd2, 16'hFFFD}, 32'h0000_3018);
    check("beq_taken", {30'd0, dif.pc_src}, 32'd1);
    check("beq_imm", dif.ext_imm, 32'hFFFF_FFFD);
    dif.wb_we   = 1'b1;
    dif.wb_addr = 5'd2;
    dif.wb_data = 32'd8;
    #1;
    check("beq_byp_nt", {30'd0, dif.pc_src}, 32'd0);
    tick();
    dif.wb_we = 1'b0;
    #1;
    check("beq_not", {30'd0, dif.pc_src}, 32'd0);
    check("beq_rt", dif.rt_data_d, 32'd8);

    // Jumps.
    load_instr({6'b000011, 26'h000_0C00}, 32'h0000_3008);
    check("jal_src", {30'd0, dif.pc_src}, 32'd2);
    check("jal_index", dif.ext_index, 32'h0000_3000);
    load_instr({6'b000010, 26'h3FF_FFFF}, 32'hA000_0010);
    check("j_src", {30'd0, dif.pc_src}, 32'd2);
    check("j_index", dif.ext_index, 32'hAFFF_FFFC);
    wr(5'd31, 32'h0000_300C);
    load_instr({6'd0, 5'd31, 15'd0, 6'b001000}, 32'h0000_3020);
    check("jr_src", {30'd0, dif.pc_src}, 32'd3);
    check("jr_target", dif.gpr_rs, 32'h0000_300C);
    load_instr({6'd0, 5'd31, 15'd0, 6'b001001}, 32'h0000_3024);
    check("jalr_not_jr", {30'd0, dif.pc_src}, 32'd0);
    load_instr({6'b111111, 5'd1, 5'd1, 16'h0001}, 32'h0000_3028);
    check("undef_op", {30'd0, dif.pc_src}, 32'd0);

    // Forwarding on bne $3,$0.
    load_instr({6'b000101, 5'd3, 5'd0, 16'h0004}, 32'h0000_302C);
    dif.fwd_rs_sel = 2'd2;
    #1;
    check("fwd_m_src", {30'd0, dif.pc_src}, 32'd1);
    check("fwd_m_rs", dif.rs_data_d, 32'h0000_0001);
    dif.fwd_rs_sel = 2'd0;
    #1;
    check("fwd_rf_src", {30'd0, dif.pc_src}, 32'd0);
    dif.fwd_rs_sel = 2'd1;
    #1;
    check("fwd_e_rs", dif.rs_data_d, 32'h0000_0055);
    dif.fwd_rs_sel = 2'd3;
    #1;
    check("fwd_rsv_rs", dif.rs_data_d, 32'h0000_0000);
    dif.fwd_rs_sel = 2'd0;
    dif.fwd_rt_sel = 2'd1;
    #1;
    check("fwd_e_rt", dif.rt_data_d, 32'h0000_0055);
    check("fwd_rt_src", {30'd0, dif.pc_src}, 32'd1);
    dif.fwd_rt_sel = 2'd0;
    #1;

    // Stall: A is held for three cycles while B waits. A write-back during the stall still lands.
    load_instr(32'h2001_0001, 32'h0000_0100);
    dif.instr_f = 32'h0800_0010;
    dif.pc4_f   = 32'h0000_0104;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        dif.wb_we   = 1'b1;
        dif.wb_addr = 5'd9;
        dif.wb_data = 32'h0000_0099;
      end else begin
        dif.wb_we   = 1'b0;
      end
      tick();
      check($sformatf("stall_instr%0d", c), dif.instr_d, 32'h2001_0001);
      check($sformatf("stall_pc4_%0d", c), dif.pc4_d, 32'h0000_0100);
    end
    dif.wb_we = 1'b0;
    dif.en_d  = 1'b1;
    tick();
    dif.en_d = 1'b0;
    check("rel_instr", dif.instr_d, 32'h0800_0010);
    check("rel_pc4", dif.pc4_d, 32'h0000_0104);
    check("rel_src", {30'd0, dif.pc_src}, 32'd2);
    load_instr(rs_probe(5'd9), 32'h0000_0108);
    check("stall_wb", dif.rs_data_d, 32'h0000_0099);

    // Reset in mid-operation overrides en_d and drops a pending write.
    dif.en_d    = 1'b1;
    dif.instr_f = 32'h1234_5678;
    dif.wb_we   = 1'b1;
    dif.wb_addr = 5'd1;
    dif.wb_data = 32'h0000_0077;
    reset       = 1'b1;
    tick();
    reset     = 1'b0;
    dif.wb_we = 1'b0;
    dif.en_d  = 1'b0;
    #1;
    check("mrst_instr", dif.instr_d, 32'h0000_0000);
    check("mrst_pc4", dif.pc4_d, 32'h0000_3004);
    load_instr(rs_probe(5'd1), 32'h0000_3008);
    check("mrst_r1", dif.rs_data_d, 32'h0000_0000);
    load_instr(rs_probe(5'd31), 32'h0000_300C);
    check("mrst_r31", dif.rs_data_d, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage (D) of the five-stage MIPS pipeline. It holds the IF/ID pipeline register, the 32×32 general register file, D-stage operand forwarding and early branch/jump resolution. It consumes the fetched instruction and PC+4 from the fetch stage. It returns `pc_src`, `ext_imm`, `ext_index` and `gpr_rs`, which the fetch stage uses to select the next PC. Branches and jumps have one architectural delay slot, so this stage never flushes the instruction already being fetched.

## Interface
Parameters:
- `RESET_PC4`, default 32'h00003004: value loaded into `pc4_d` on reset.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `en_d` in 1: IF/ID enable; 0 holds `instr_d`/`pc4_d` (stall).
- `instr_f` in 32: instruction from the fetch stage.
- `pc4_f` in 32: PC+4 from the fetch stage.
- `wb_we` in 1: register-file write enable (W stage).
- `wb_addr` in 5: register-file write address.
- `wb_data` in 32: register-file write data.
- `fwd_rs_sel` in 2: rs operand source; 0 = register file, 1 = `fwd_e_data`, 2 = `fwd_m_data`, 3 = reserved (treated as 0).
- `fwd_rt_sel` in 2: rt operand source, same encoding as `fwd_rs_sel`.
- `fwd_e_data` in 32: forwarded value from the E stage.
- `fwd_m_data` in 32: forwarded value from the M stage.
- `instr_d` out 32: IF/ID instruction register.
- `pc4_d` out 32: IF/ID PC+4 register.
- `rs_data_d` out 32: forwarded rs operand.
- `rt_data_d` out 32: forwarded rt operand.
- `gpr_rs` out 32: equal to `rs_data_d`; the jr target.
- `ext_imm` out 32: sign-extended `instr_d[15:0]`.
- `ext_index` out 32: `{pc4_d[31:28], instr_d[25:0], 2'b00}`.
- `pc_src` out 2: next-PC select; 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.

## Operation
IF/ID register:
- On reset: `instr_d` ← 0 (nop), `pc4_d` ← `RESET_PC4`.
- Else if `en_d` = 1: load `instr_f`/`pc4_f`.
- Else: hold both values.

Register file:
- 32 registers, all cleared on reset.
- Write on the clock edge when `wb_we` = 1 and `wb_addr` ≠ 0.
- `$0` always reads 0; writes to `$0` are ignored.
- Reads are combinational on `instr_d[25:21]` (rs) and `instr_d[20:16]` (rt).
- Internal bypass: when a read address equals `wb_addr`, `wb_we` = 1 and the address is ≠ 0, the read returns `wb_data` in the same cycle.

Forwarding:
- `rs_data_d`/`rt_data_d` come from a 3:1 mux driven by `fwd_*_sel`.
- The bypassed register-file value is mux input 0.

Decode (opcode = `instr_d[31:26]`, funct = `instr_d[5:0]`):
- beq (000100): `pc_src` = 1 if `rs_data_d` == `rt_data_d`, else 0.
- bne (000101): `pc_src` = 1 if `rs_data_d` != `rt_data_d`, else 0.
- j (000010) and jal (000011): `pc_src` = 2.
- jr (opcode 000000, funct 001000): `pc_src` = 3.
- Any other encoding, including nop and undefined opcodes: `pc_src` = 0.

Arithmetic and width rules:
- Comparison is full 32-bit equality.
- `ext_imm` is the 16-bit immediate sign-extended to 32 bits, not shifted; the fetch stage applies the <<2.
- The branch target is the delay-slot PC plus the offset.

## Timing
- All outputs are combinational from IF/ID state, register-file state and the forwarding inputs.
- Outputs are valid in the same cycle the instruction occupies D.
- Register-file write latency: 1 edge. A same-cycle read sees the written value through the bypass.
- Reset values: `instr_d` = 0, `pc4_d` = `RESET_PC4`, `pc_src` = 0, `ext_imm` = 0, `ext_index` = {`RESET_PC4`[31:28], 28'b0}, `rs_data_d`/`rt_data_d`/`gpr_rs` = 0 (with `fwd_*_sel` = 0).
- Stall (`en_d` = 0): the D instruction is held and `pc_src` keeps being re-evaluated. The fetch stage is stalled by the same hazard signal, so `pc_src` has no effect until `en_d` returns to 1. Forwarded values may change during a stall; the final cycle before release is the one that counts.
- Simultaneous write-back and stall: the register file still writes, and the IF/ID register still holds.
- Reset mid-operation overrides `en_d` and any pending write; a write in the reset cycle is dropped.
- No flush: the delay-slot instruction always enters D.

## Test plan
- Reset: assert `reset` 1 cycle → `instr_d` = 0, `pc4_d` = 32'h00003004, `pc_src` = 0, `rs_data_d` = 0 for every rs.
- Register file with bypass:
  - Write `$5` = 32'hDEADBEEF with `instr_d` reading rs = 5 in the same cycle → `rs_data_d` = DEADBEEF before and after the edge.
  - Write to `$0` → `$0` still reads 0.
- beq resolution: `$1` = `$2` = 7, `instr_d` = beq `$1`,`$2`,-3 → `pc_src` = 1, `ext_imm` = 32'hFFFFFFFD. Set `$2` = 8 → `pc_src` = 0.
- Jumps:
  - jal index 0x0000C00 at `pc4_d` = 32'h00003008 → `pc_src` = 2, `ext_index` = 32'h00003000.
  - jr `$31` with `$31` = 32'h0000300C → `pc_src` = 3, `gpr_rs` = 32'h0000300C.
- Forwarding:
  - bne `$3`,`$0` with regfile `$3` = 0, `fwd_rs_sel` = 2, `fwd_m_data` = 1 → `pc_src` = 1.
  - Same with `fwd_rs_sel` = 0 → `pc_src` = 0.
  - `fwd_rs_sel` = 1 selects `fwd_e_data`.
- Stall: load instr A, then drive instr B with `en_d` = 0 for 3 cycles → `instr_d` stays A. Raise `en_d` → B on the next edge. `pc4_d` tracks the same way.
